change_payout: RTL
==================

// Module: change_payout
// PURPOSE
//   Change-return controller on the far side of the vending machine's change interface. It accepts
//   a change amount and pays it out as physical coins from two hoppers, one for Rs.10 and one for
//   Rs.5. It prefers Rs.10 coins, pulses the hopper motor and waits for the coin-exit sensor.
//   It tracks hopper stock and reports any shortfall. Sits between the vending FSM and the hoppers.
// PARAMETERS
//   AMT_W       5   width of amounts, in Rs.5 units (max 31 units = Rs.155)
//   CNT_W       8   width of each hopper stock counter (saturating)
//   PULSE_CYC   4   motor-on pulse length, in clk cycles (>=1)
//   TIMEOUT_CYC 64  wait-for-sensor limit after motor pulse (used only with macro)
// PORTS
//   clk            in   1      rising-edge clock
//   reset_n        in   1      asynchronous active-low reset
//   pay_req        in   1      change request valid
//   pay_amt        in   AMT_W  requested change, Rs.5 units; sampled on accept
//   pay_ready      out  1      high only in IDLE; accept = pay_req & pay_ready
//   pay_done       out  1      one-cycle pulse when payout finishes
//   pay_short      out  1      valid with pay_done: 1 if paid_amt < requested
//   paid_amt       out  AMT_W  amount actually paid, Rs.5 units; held until next accept
//   hopper10_motor out  1      Rs.10 hopper eject drive
//   hopper5_motor  out  1      Rs.5 hopper eject drive
//   coin10_sensed  in   1      one-cycle pulse: Rs.10 coin left hopper (synchronous)
//   coin5_sensed   in   1      one-cycle pulse: Rs.5 coin left hopper (synchronous)
//   load10, load5  in   1      refill strobe: add one coin to that hopper's stock
//   stock10,stock5 out  CNT_W  current hopper stock
// BEHAVIOUR
//   Reset (async, reset_n=0): state IDLE; all outputs 0; stock counters 0; pay_ready goes to 1
//     after reset is released. Motors drop immediately when reset is asserted, including mid-payout.
//   States: IDLE -> SELECT -> DRIVE10/DRIVE5 -> WAIT10/WAIT5 -> SELECT ... -> DONE -> IDLE.
//   IDLE: on accept, latch rem=pay_amt, clear paid_amt, go to SELECT.
//   SELECT (1 cycle): if rem>=2 and stock10>0, go to DRIVE10. Else if rem>=1 and stock5>0,
//     go to DRIVE5. Else go to DONE.
//   DRIVEx: motor high for exactly PULSE_CYC cycles, then go to WAITx with the motor low.
//   Sensor pulse for the active hopper, seen in DRIVEx or WAITx:
//     - rem -= 2 (Rs.10) or 1 (Rs.5);
//     - paid_amt += the same amount;
//     - stock of that hopper decrements;
//     - go to SELECT. If the pulse arrives during DRIVE, the motor drops the same cycle.
//   Sensor pulses in any other state, or for the inactive hopper, are ignored.
//   DONE (1 cycle): pay_done=1, pay_short=(rem!=0), then go to IDLE.
//   pay_amt=0: sequence is IDLE->SELECT->DONE; paid_amt=0, pay_short=0.
//   Latency for a single coin: accept + 1 (SELECT) + PULSE_CYC + sensor delay + 1 (SELECT) + 1 (DONE).
//   Stock arithmetic: a load increments the stock, saturating at 2^CNT_W-1. A load and a
//     decrement on the same hopper in the same cycle leave the stock unchanged. Loads are
//     accepted in every state.
//   Mode: odd rem with stock5=0 pays the Rs.10 coins only and finishes with pay_short=1; it never
//     overpays.
// CONFIGURATION
//   VM_PAYOUT_TIMEOUT_EN defined: a counter runs in WAITx. After TIMEOUT_CYC cycles with no
//     sensor pulse, that hopper's stock is forced to 0 (treated as jammed/empty) and the FSM goes
//     to SELECT, which can fall back to the other coin.
//   Not defined: WAITx waits indefinitely; no timeout counter is synthesized.
// STRUCTURE
//   vm_pkg: payout state enum, COIN5_UNITS=1, COIN10_UNITS=2 localparams.
//   Sub-module payout_hopper_drv, instantiated twice (one per hopper):
//     - motor pulse counter and timeout counter;
//     - start/sensed/timeout handshake with the top FSM.
// TESTING
//   1. stock10=5, stock5=5, pay_amt=3 (Rs.15) -> one Rs.10 then one Rs.5;
//      paid_amt=3, pay_short=0, stock10=4, stock5=4.
//   2. stock10=0, stock5=2, pay_amt=4 -> two Rs.5 coins, paid_amt=2, pay_short=1.
//   3. pay_amt=0 -> pay_done exactly 2 cycles after accept, no motor activity.
//   4. Sensor pulse 1 cycle into DRIVE10 -> motor drops that cycle; coin counted once.
//      A stray coin5_sensed in IDLE leaves stock5 unchanged.
//   5. reset_n low during WAIT10 -> motors 0, outputs 0, stocks 0 immediately;
//      after release, pay_ready=1.
//   6. With VM_PAYOUT_TIMEOUT_EN: pay_amt=2, stock10=1, stock5=3, no coin10_sensed ->
//      after 64 cycles stock10=0, then two Rs.5 coins paid, paid_amt=2, pay_short=0.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: payout FSM state encoding and coin denominations in Rs.5 units
package vm_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, DRIVE10, WAIT10, DRIVE5, WAIT5, DONE} pay_state_t;
  localparam int COIN5_UNITS = 1;
  localparam int COIN10_UNITS = 2;
endpackage

// File: rtl/payout_hopper_drv.sv
// payout_hopper_drv: motor pulse timing for one hopper; VM_PAYOUT_TIMEOUT_EN adds a
// wait-for-sensor timeout that flags a jammed or empty hopper
module payout_hopper_drv #(
  parameter int PULSE_CYC = 4
`ifdef VM_PAYOUT_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic drive,
  input  logic sensed,
`ifdef VM_PAYOUT_TIMEOUT_EN
  input  logic waiting,
`endif
  output logic motor,
  output logic pulse_end,
  output logic timeout
);
  localparam int PW = $clog2(PULSE_CYC + 1);
  logic [PW-1:0] pcnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pcnt <= '0;
    else pcnt <= drive ? pcnt + 1'b1 : '0;
  // a coin seen mid-pulse cuts the motor in the same cycle
  assign motor = drive & ~sensed;
  assign pulse_end = drive & (pcnt == PW'(PULSE_CYC - 1));
`ifdef VM_PAYOUT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= waiting ? tcnt + 1'b1 : '0;
  assign timeout = waiting & ~sensed & (tcnt == TW'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/change_payout.sv
// change_payout: pays change from Rs.10/Rs.5 hoppers (Rs.10 first) and tracks hopper stock
// VM_PAYOUT_TIMEOUT_EN: a hopper silent for TIMEOUT_CYC cycles is zeroed and skipped
module change_payout
  import vm_pkg::*;
#(
  parameter int AMT_W = 5,
  parameter int CNT_W = 8,
  parameter int PULSE_CYC = 4
`ifdef VM_PAYOUT_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pay_req,
  input  logic [AMT_W-1:0] pay_amt,
  output logic             pay_ready,
  output logic             pay_done,
  output logic             pay_short,
  output logic [AMT_W-1:0] paid_amt,
  output logic             hopper10_motor,
  output logic             hopper5_motor,
  input  logic             coin10_sensed,
  input  logic             coin5_sensed,
  input  logic             load10,
  input  logic             load5,
  output logic [CNT_W-1:0] stock10,
  output logic [CNT_W-1:0] stock5
);
  pay_state_t state, state_nx;
  logic [AMT_W-1:0] rem;
  logic drive10, drive5, wait10, wait5, sens10, sens5, end10, end5, to10, to5;
  function automatic logic [CNT_W-1:0] stock_nx(input logic [CNT_W-1:0] s, input logic ld,
                                                input logic dec, input logic clr);
    stock_nx = clr ? CNT_W'(ld) : (ld & ~dec & ~&s) ? s + 1'b1 : (dec & ~ld) ? s - 1'b1 : s;
  endfunction
  assign drive10 = state == DRIVE10;
  assign drive5 = state == DRIVE5;
  assign wait10 = state == WAIT10;
  assign wait5 = state == WAIT5;
  assign sens10 = coin10_sensed & (drive10 | wait10);
  assign sens5 = coin5_sensed & (drive5 | wait5);
  payout_hopper_drv #(
    .PULSE_CYC(PULSE_CYC)
`ifdef VM_PAYOUT_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_drv10 (
    .clk(clk),
    .reset_n(reset_n),
    .drive(drive10),
    .sensed(sens10),
`ifdef VM_PAYOUT_TIMEOUT_EN
    .waiting(wait10),
`endif
    .motor(hopper10_motor),
    .pulse_end(end10),
    .timeout(to10)
  );
  payout_hopper_drv #(
    .PULSE_CYC(PULSE_CYC)
`ifdef VM_PAYOUT_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_drv5 (
    .clk(clk),
    .reset_n(reset_n),
    .drive(drive5),
    .sensed(sens5),
`ifdef VM_PAYOUT_TIMEOUT_EN
    .waiting(wait5),
`endif
    .motor(hopper5_motor),
    .pulse_end(end5),
    .timeout(to5)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = pay_req ? SELECT : IDLE;
      SELECT:  state_nx = (rem >= AMT_W'(COIN10_UNITS) && stock10 != '0) ? DRIVE10 :
                          (rem >= AMT_W'(COIN5_UNITS) && stock5 != '0) ? DRIVE5 : DONE;
      DRIVE10: state_nx = sens10 ? SELECT : end10 ? WAIT10 : DRIVE10;
      WAIT10:  state_nx = (sens10 | to10) ? SELECT : WAIT10;
      DRIVE5:  state_nx = sens5 ? SELECT : end5 ? WAIT5 : DRIVE5;
      WAIT5:   state_nx = (sens5 | to5) ? SELECT : WAIT5;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      rem <= '0;
      paid_amt <= '0;
      stock10 <= '0;
      stock5 <= '0;
    end else begin
      state <= state_nx;
      stock10 <= stock_nx(stock10, load10, sens10, to10);
      stock5 <= stock_nx(stock5, load5, sens5, to5);
      if (state == IDLE && pay_req) begin
        rem <= pay_amt;
        paid_amt <= '0;
      end else if (sens10) begin
        rem <= rem - AMT_W'(COIN10_UNITS);
        paid_amt <= paid_amt + AMT_W'(COIN10_UNITS);
      end else if (sens5) begin
        rem <= rem - AMT_W'(COIN5_UNITS);
        paid_amt <= paid_amt + AMT_W'(COIN5_UNITS);
      end
    end
  // ready is held low while reset is asserted, IDLE or not
  assign pay_ready = (state == IDLE) & reset_n;
  assign pay_done = state == DONE;
  assign pay_short = pay_done & (rem != '0);
endmodule
